instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL expose parameter PC_W, default 10, meaning instruction-memory word-address width.
REQ-002 The block SHALL expose parameter RESET_PC, default 0, meaning program start address.
REQ-003 The block SHALL expose parameter NOP_INSTN, default 32'hFFFF_FFFF, meaning the bubble word; opcode 6'b111111 decodes to all control lines zero.
REQ-004 The block SHALL have the following ports; one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin or restart fetch at RESET_PC
- stall  in  1  downstream busy; freeze all fetch state
- prog_end  in  PC_W  last valid instruction address
- imem_addr  out  PC_W  instruction-memory address, combinational from PC
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- instn  out  32  registered instruction (IR) to decoder
- state  out  2  branch state register to decoder: NORMAL=00, BEQ_IN=01, EQUAL=10
- next_state  in  2  decoder's next branch state
- beq_enable  in  1  decoder branch-hold request
- PCSrc  in  1  branch taken, valid in BEQ_IN
- busy  out  1  high in RUN
- done  out  1  high in DONE

Function
REQ-005 Control FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after fetching prog_end; DONE->RUN on start; start SHALL be ignored in RUN.
REQ-006 On IDLE->RUN or DONE->RUN, PC SHALL load RESET_PC, IR SHALL load NOP_INSTN, state SHALL load NORMAL.
REQ-007 In RUN with stall=1, PC, IR, state, branch target and FSM SHALL all hold.
REQ-008 In RUN with stall=0 and beq_enable=0: IR <= imem_rdata, IR_PC <= PC, PC <= PC+1 modulo 2^PC_W.
REQ-009 In RUN with stall=0, state SHALL load next_state every cycle; outside RUN state SHALL hold NORMAL.
REQ-010 In state NORMAL with beq_enable=1 and stall=0: PC SHALL hold, IR <= NOP_INSTN, target <= IR_PC + 1 + sign-extended IR[15:0], truncated to PC_W.
REQ-011 In state BEQ_IN with beq_enable=1 (taken) and stall=0: PC <= target, IR <= NOP_INSTN.
REQ-012 In state BEQ_IN with beq_enable=0 (not taken), fetch SHALL proceed per REQ-008 from the held PC.
REQ-013 In state EQUAL, fetch SHALL proceed per REQ-008 from the branch target.
REQ-014 Taken-branch penalty SHALL be exactly 2 bubble cycles; not-taken penalty exactly 1.
REQ-015 A fetch per REQ-008 with PC==prog_end SHALL move FSM to DONE on the same edge; if that instruction is a BEQ, DONE SHALL be deferred until the branch resolves, and a taken branch SHALL return to normal fetch.
REQ-016 In IDLE and DONE, IR SHALL hold NOP_INSTN and PC SHALL hold.
REQ-017 busy and done SHALL be registered-state decodes, mutually exclusive.

Reset
REQ-018 rst_n low SHALL immediately force FSM=IDLE, PC=RESET_PC, IR=NOP_INSTN, IR_PC=0, target=0, state=NORMAL, busy=0, done=0, regardless of clk or any in-flight branch.
REQ-019 After rst_n deasserts, no fetch SHALL occur until start is sampled high.

Configuration
REQ-020 With macro FETCH_BRANCH_CNT_EN defined, the block SHALL add output br_taken_cnt (16 bits), cleared by reset and on start, incremented on each REQ-011 event, saturating at 16'hFFFF.
REQ-021 Without FETCH_BRANCH_CNT_EN, br_taken_cnt and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-022 Straight line: imem[0..3] non-branch, prog_end=3, start pulse -> instn shows imem[0..3] on 4 consecutive cycles, then done=1, instn=NOP_INSTN.
REQ-023 Taken BEQ at addr 2, offset +3, PCSrc=1 -> two NOP cycles after BEQ, next fetched address is 6, state sequence 00,01,10,00.
REQ-024 Not-taken BEQ at addr 2, PCSrc=0 -> one NOP cycle, next fetched address is 3.
REQ-025 stall=1 for 3 cycles during BEQ_IN -> PC, IR, state unchanged throughout; branch resolves correctly after release.
REQ-026 rst_n pulsed low mid-branch (state=BEQ_IN) -> outputs at reset values asynchronously; start then fetches from RESET_PC.
REQ-027 With FETCH_BRANCH_CNT_EN, backward BEQ offset -1 taken 5 times -> br_taken_cnt=5; PC wrap from 2^PC_W-1 fetches address 0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage with IR, branch-hold/redirect and IDLE/RUN/DONE control
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   start               : begin/restart fetch at RESET_PC (ignored while running)
//   stall               : freeze all fetch state
//   prog_end            : address of the last valid instruction
//   imem_addr/imem_rdata: combinational instruction-memory port
//   instn, state        : IR and branch state presented to the decoder
//   next_state, beq_enable, PCSrc : decoder feedback
//   busy, done          : RUN / DONE decodes
//   br_taken_cnt        : saturating taken-branch counter, present only with FETCH_BRANCH_CNT_EN
module instr_fetch #(
  parameter int                PC_W      = 10,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTN = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic [PC_W-1:0] prog_end,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instn,
  output logic [1:0]      state,
  input  logic [1:0]      next_state,
  input  logic            beq_enable,
  input  logic            PCSrc,
  output logic            busy,
  output logic            done
`ifdef FETCH_BRANCH_CNT_EN
  ,
  output logic [15:0]     br_taken_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
  localparam logic [1:0] NORMAL = 2'b00;
  localparam logic [1:0] BEQ_IN = 2'b01;
  localparam logic [5:0] BEQ_OP = 6'b000100;
  fsm_e            fsm_q, fsm_d;
  logic [PC_W-1:0] pc_q, pc_d, ir_pc_q, ir_pc_d, tgt_q, tgt_d, tgt;
  logic [31:0]     ir_q, ir_d;
  logic [1:0]      st_q, st_d;
  logic            hold_br, taken, end_nt, last;
  // The decoder's beq_enable already folds in PCSrc while in BEQ_IN.
  logic            unused_pcsrc;
  assign unused_pcsrc = PCSrc;
  assign imem_addr = pc_q;
  assign instn     = ir_q;
  assign state     = st_q;
  assign busy      = fsm_q == RUN;
  assign done      = fsm_q == DONE;
  assign tgt       = PC_W'(32'(ir_pc_q) + 32'd1 + {{16{ir_q[15]}}, ir_q[15:0]});
  assign hold_br   = st_q == NORMAL && beq_enable;
  assign taken     = st_q == BEQ_IN && beq_enable;
  // A BEQ sitting at prog_end that is not taken finishes the program.
  assign end_nt    = st_q == BEQ_IN && !beq_enable && ir_pc_q == prog_end;
  // A BEQ fetched at prog_end defers DONE until it resolves.
  assign last      = pc_q == prog_end && imem_rdata[31:26] != BEQ_OP;
  always_comb begin
    fsm_d   = fsm_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    tgt_d   = tgt_q;
    st_d    = st_q;
    if (fsm_q != RUN) begin
      st_d = NORMAL;
      ir_d = NOP_INSTN;
      if (start) begin
        fsm_d = RUN;
        pc_d  = RESET_PC;
      end
    end else if (!stall) begin
      st_d = next_state;
      if (hold_br) begin
        ir_d  = NOP_INSTN;
        tgt_d = tgt;
      end else if (taken) begin
        ir_d = NOP_INSTN;
        pc_d = tgt_q;
      end else if (end_nt) begin
        ir_d  = NOP_INSTN;
        fsm_d = DONE;
      end else begin
        ir_d    = imem_rdata;
        ir_pc_d = pc_q;
        pc_d    = pc_q + PC_W'(1);
        fsm_d   = last ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTN;
      ir_pc_q <= '0;
      tgt_q   <= '0;
      st_q    <= NORMAL;
    end else begin
      fsm_q   <= fsm_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      tgt_q   <= tgt_d;
      st_q    <= st_d;
    end
  end
`ifdef FETCH_BRANCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign br_taken_cnt = cnt_q;
  always_comb begin
    cnt_d = cnt_q;
    if (fsm_q != RUN && start) cnt_d = '0;
    else if (fsm_q == RUN && !stall && taken && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a small BEQ decoder model
module tb_instr_fetch;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, stall = 1'b0, PCSrc = 1'b0;
  logic        beq_enable, busy, done;
  logic [9:0]  prog_end = 10'd3, imem_addr;
  logic [31:0] imem_rdata, instn;
  logic [1:0]  state, next_state;
  logic [31:0] mem [1024];
  int          n_cmp = 0, n_err = 0;
  localparam logic [31:0] NOP = 32'hFFFF_FFFF;
`ifdef FETCH_BRANCH_CNT_EN
  logic [15:0] br_taken_cnt;
`endif
  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];
  always_comb begin
    beq_enable = 1'b0;
    next_state = 2'b00;
    if (state == 2'b00 && instn[31:26] == 6'b000100) begin
      beq_enable = 1'b1;
      next_state = 2'b01;
    end else if (state == 2'b01) begin
      beq_enable = PCSrc;
      next_state = PCSrc ? 2'b10 : 2'b00;
    end
  end
  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .prog_end(prog_end),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instn(instn), .state(state),
    .next_state(next_state), .beq_enable(beq_enable), .PCSrc(PCSrc), .busy(busy), .done(done)
`ifdef FETCH_BRANCH_CNT_EN
    , .br_taken_cnt(br_taken_cnt)
`endif
  );
  function automatic logic [31:0] plain(input int a);
    return 32'h2000_0000 | 32'(a);
  endfunction
  function automatic logic [31:0] beq(input int off);
    return {6'b000100, 10'd0, 16'(off)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = plain(i);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_instn", instn, NOP);
    chk("rst_state", state, 0);
    chk("rst_addr", imem_addr, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_addr", imem_addr, 0);
    chk("idle_busy", busy, 0);
    chk("idle_instn", instn, NOP);
    // straight line 0..3, start held once mid-run must be ignored
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("sl_busy", busy, 1);
    chk("sl_ir0", instn, NOP);
    chk("sl_addr0", imem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      start = (i == 2);
      tick;
      chk($sformatf("sl_instn%0d", i), instn, plain(i));
    end
    start = 1'b0;
    chk("sl_done", done, 1);
    chk("sl_busy_end", busy, 0);
    tick;
    chk("sl_nop", instn, NOP);
    chk("sl_done2", done, 1);
    chk("sl_pc_hold", imem_addr, 4);
    // taken BEQ at 2, offset +3
    mem[2] = beq(3);
    prog_end = 10'd7;
    PCSrc = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("tk_restart_addr", imem_addr, 0);
    chk("tk_restart_done", done, 0);
    tick;
    tick;
    tick;
    chk("tk_beq", instn, beq(3));
    chk("tk_st0", state, 0);
    tick;
    chk("tk_bub1", instn, NOP);
    chk("tk_st1", state, 1);
    chk("tk_hold", imem_addr, 3);
    tick;
    chk("tk_bub2", instn, NOP);
    chk("tk_st2", state, 2);
    chk("tk_target", imem_addr, 6);
    tick;
    chk("tk_fetch6", instn, plain(6));
    chk("tk_st3", state, 0);
    tick;
    chk("tk_fetch7", instn, plain(7));
    chk("tk_done", done, 1);
    // not-taken BEQ at 2
    PCSrc = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    chk("nt_beq", instn, beq(3));
    tick;
    chk("nt_bub", instn, NOP);
    chk("nt_st1", state, 1);
    tick;
    chk("nt_fetch3", instn, plain(3));
    chk("nt_st0", state, 0);
    chk("nt_addr", imem_addr, 4);
    repeat (4) tick;
    chk("nt_last", instn, plain(7));
    chk("nt_done", done, 1);
    // stall for 3 cycles inside BEQ_IN
    PCSrc = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    chk("st_in", state, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("st_state%0d", i), state, 1);
      chk($sformatf("st_addr%0d", i), imem_addr, 3);
      chk($sformatf("st_ir%0d", i), instn, NOP);
    end
    stall = 1'b0;
    tick;
    chk("st_rel_state", state, 2);
    chk("st_rel_addr", imem_addr, 6);
    tick;
    chk("st_fetch6", instn, plain(6));
    tick;
    chk("st_done", done, 1);
    // asynchronous reset while in BEQ_IN
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    chk("ar_pre", state, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_addr", imem_addr, 0);
    chk("ar_instn", instn, NOP);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    #2 rst_n = 1'b1;
    tick;
    chk("ar_idle_addr", imem_addr, 0);
    chk("ar_idle_busy", busy, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("ar_fetch0", instn, plain(0));
    chk("ar_addr1", imem_addr, 1);
    // BEQ at prog_end=0 jumping to 1022, PC wrap, deferred DONE
    mem[0] = beq(1021);
    prog_end = 10'd0;
    PCSrc = 1'b1;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("wr_beq", instn, beq(1021));
    chk("wr_defer_busy", busy, 1);
    chk("wr_defer_done", done, 0);
    tick;
    chk("wr_st1", state, 1);
    tick;
    chk("wr_target", imem_addr, 1022);
    tick;
    chk("wr_f1022", instn, plain(1022));
    tick;
    chk("wr_f1023", instn, plain(1023));
    chk("wr_wrap", imem_addr, 0);
    tick;
    chk("wr_f0", instn, beq(1021));
    chk("wr_busy2", busy, 1);
    PCSrc = 1'b0;
    tick;
    chk("wr_nt_st", state, 1);
    chk("wr_nt_busy", busy, 1);
    tick;
    chk("wr_end_done", done, 1);
    chk("wr_end_busy", busy, 0);
    chk("wr_end_ir", instn, NOP);
`ifdef FETCH_BRANCH_CNT_EN
    chk("wr_cnt", br_taken_cnt, 1);
`endif
    // backward BEQ offset -1 at address 1, taken 5 times
    mem[0] = plain(0);
    mem[1] = beq(-1);
    mem[2] = plain(2);
    prog_end = 10'd3;
    PCSrc = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
`ifdef FETCH_BRANCH_CNT_EN
    chk("bk_cnt_clr", br_taken_cnt, 0);
`endif
    tick;
    chk("bk_f0", instn, plain(0));
    for (int k = 1; k <= 5; k++) begin
      tick;
      chk($sformatf("bk_beq%0d", k), instn, beq(-1));
      tick;
      tick;
      chk($sformatf("bk_tgt%0d", k), imem_addr, 1);
      chk($sformatf("bk_st%0d", k), state, 2);
    end
    tick;
    PCSrc = 1'b0;
    tick;
    tick;
    chk("bk_f2", instn, plain(2));
    chk("bk_addr3", imem_addr, 3);
`ifdef FETCH_BRANCH_CNT_EN
    chk("bk_cnt5", br_taken_cnt, 5);
`endif
    tick;
    chk("bk_done", done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
